// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the RV32M sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = 32);
    logic            start;
    logic            kill;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (output start, kill, Funct3, SrcA, SrcB, input busy, done, Result);
    modport slave  (input start, kill, Funct3, SrcA, SrcB, output busy, done, Result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_FAST_PATH_EN to let trivial operations (x0 multiply, /0, signed overflow) skip CALC.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_nxt;
    logic              load, step, write_res;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              res_neg, div_zero;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0]   result_q, final_result;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic              in_is_div, in_is_rem, in_div_zero, in_res_neg;
    logic [XLEN-1:0]   in_mag_a, in_mag_b;
    logic              fast_hit;

    logic [XLEN:0]     mul_sum, rem_shift;
    logic [XLEN-1:0]   rem_sub, quo, rem;
    logic              rem_ge;
    logic [2*XLEN-1:0] prod;

    // Remainder follows the dividend's sign; everything else follows the product/quotient sign.
    always_comb begin
        in_is_div   = bus.Funct3[2];
        in_is_rem   = bus.Funct3[2] & bus.Funct3[1];
        a_signed    = ~bus.Funct3[0] | (bus.Funct3 == 3'b001);
        b_signed    = (~bus.Funct3[2] & ~bus.Funct3[1]) | (bus.Funct3[2] & ~bus.Funct3[0]);
        a_neg       = a_signed & bus.SrcA[XLEN-1];
        b_neg       = b_signed & bus.SrcB[XLEN-1];
        in_mag_a    = a_neg ? (-bus.SrcA) : bus.SrcA;
        in_mag_b    = b_neg ? (-bus.SrcB) : bus.SrcB;
        in_div_zero = in_is_div & (bus.SrcB == '0);
        in_res_neg  = in_is_rem ? a_neg : (a_neg ^ b_neg);
    end

`ifdef MULDIV_FAST_PATH_EN
    logic [XLEN-1:0] fast_result;

    always_comb begin
        fast_hit    = 1'b0;
        fast_result = '0;
        if (!in_is_div && ((bus.SrcA == '0) || (bus.SrcB == '0))) begin
            fast_hit = 1'b1;
        end else if (in_div_zero) begin
            fast_hit    = 1'b1;
            fast_result = in_is_rem ? bus.SrcA : '1;
        end else if (in_is_div && !bus.Funct3[0] && (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.SrcB == '1)) begin
            fast_hit    = 1'b1;
            fast_result = in_is_rem ? '0 : bus.SrcA;
        end
    end
`else
    assign fast_hit = 1'b0;
`endif

    // Multiply: add into the upper half and shift the pair right, so the low half collects product bits.
    // Divide: upper half is the partial remainder, lower half collects quotient bits.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (mag_b[0] ? {1'b0, mag_a} : '0);
        rem_shift = {acc[2*XLEN-1:XLEN], mag_a[XLEN-1]};
        rem_ge    = (rem_shift >= {1'b0, mag_b});
        rem_sub   = rem_shift[XLEN-1:0] - mag_b;
        if (op[2]) begin
            acc_nxt = {(rem_ge ? rem_sub : rem_shift[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
        end else begin
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = res_neg ? (-acc_nxt) : acc_nxt;
        quo  = acc_nxt[XLEN-1:0];
        rem  = acc_nxt[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 final_result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_result = div_zero ? '1 : (res_neg ? (-quo) : quo);
            default:                final_result = res_neg ? (-rem) : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // kill wins over start in every state; start is only honoured outside CALC.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        write_res = 1'b0;
        case (state)
            CALC: begin
                if (bus.kill) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state_nxt = DONE;
                        write_res = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.kill) begin
                    state_nxt = IDLE;
                end else if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = fast_hit ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op       <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            res_neg  <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                op       <= bus.Funct3;
                mag_a    <= in_mag_a;
                mag_b    <= in_mag_b;
                res_neg  <= in_res_neg;
                div_zero <= in_div_zero;
                acc      <= '0;
                cnt      <= '0;
`ifdef MULDIV_FAST_PATH_EN
                if (fast_hit) result_q <= fast_result;
`endif
            end else if (step) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (op[2]) mag_a <= mag_a << 1;
                else       mag_b <= mag_b >> 1;
            end
            if (write_res) result_q <= final_result;
        end
    end

    assign bus.busy   = (state == CALC);
    assign bus.done   = (state == DONE);
    assign bus.Result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues expected results, a monitor checks each done pulse.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    logic [31:0] mon_exp;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Reference behaviour straight from RV32M arithmetic rules.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        int          ia, ib;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ub  = longint'({32'd0, b});
        up  = {32'd0, a} * {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_PATH_EN
        if (!f3[2] && (a == 0 || b == 0)) return 1;
        if (f3[2] && b == 0) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] want, input bit expect_done, input bit sync);
        if (sync) @(negedge clk);
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
        bus.start  = 1'b1;
        if (expect_done) begin
            exp_q.push_back(want);
            last_exp = want;
        end
    endtask

    // Waits for done, counting cycles from the start cycle; optionally pulses a stray start mid-CALC.
    task automatic waitDone(input int exp_lat, input int pulse_at);
        int k;
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        for (k = 1; k <= 3 * XLEN; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == pulse_at) begin
                bus.start  = 1'b1;
                bus.Funct3 = 3'b101;
                bus.SrcA   = $urandom();
                bus.SrcB   = $urandom();
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("done_latency", seen ? k : 0, exp_lat);
        checkOutput("busy_cycles", busy_cnt, exp_lat - 1);
    endtask

    task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
        applyStimulus(f3, a, b, want, 1'b1, 1'b1);
        waitDone(expLatency(f3, a, b), 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("result", bus.Result, mon_exp);
            end
            checkOutput("busy_done_excl", 32'(bus.busy), 32'd0);
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        checks     = 0;
        errors     = 0;
        last_exp   = 32'd0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.Funct3 = 3'd0;
        bus.SrcA   = 32'd0;
        bus.SrcB   = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_result", bus.Result, 32'd0);
        rst_n = 1'b1;

        runOp(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        runOp(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        runOp(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        runOp(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        runOp(3'b101, 32'd100, 32'd7, 32'd14);
        runOp(3'b111, 32'd100, 32'd7, 32'd2);
        runOp(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        runOp(3'b111, 32'd5, 32'd0, 32'd5);
        runOp(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runOp(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        runOp(3'b110, 32'd9, 32'd0, 32'd9);
        runOp(3'b000, 32'd0, 32'd12345, 32'd0);

        // Kill in cycle 10 of a divide: no done, Result holds.
        applyStimulus(3'b100, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 10) bus.kill = 1'b1;
        end
        @(negedge clk);
        bus.kill = 1'b0;
        checkOutput("kill_busy", 32'(bus.busy), 32'd0);
        repeat (2 * XLEN) @(negedge clk);
        checkOutput("kill_result_hold", bus.Result, last_exp);
        runOp(3'b000, 32'd3, 32'd4, 32'd12);

        // Stray start in cycle 5 of CALC must be ignored.
        applyStimulus(3'b000, 32'd9, 32'd11, 32'd99, 1'b1, 1'b1);
        waitDone(XLEN + 1, 5);
        repeat (2 * XLEN) @(negedge clk);

        // Back-to-back: second start issued in the done cycle.
        applyStimulus(3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
        waitDone(XLEN + 1, 0);
        applyStimulus(3'b101, 32'd1000, 32'd3, 32'd333, 1'b1, 1'b0);
        waitDone(XLEN + 1, 0);

        // Asynchronous reset mid-CALC clears outputs at once and cancels the op.
        applyStimulus(3'b000, 32'd5, 32'd6, 32'd30, 1'b1, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        last_exp = 32'd0;
        #1;
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset_done", 32'(bus.done), 32'd0);
        checkOutput("midreset_result", bus.Result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * XLEN) @(negedge clk);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pickOperand();
            b  = pickOperand();
            runOp(f3, a, b, refModel(f3, a, b));
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
